// File: rtl/conv_ctrl_pkg.sv
// Shared types and widths for the convolution stream controller.
// Holds the FSM state enum, counter widths and the output tag bundle.
package conv_ctrl_pkg;

  localparam int PKG_MAX_IMG_W   = 640;
  localparam int PKG_MAX_IMG_H   = 640;
  localparam int PKG_NKX         = 3;
  localparam int PKG_NKY         = 3;
  localparam int PKG_MAX_STRIDE  = 2;
  localparam int PKG_MAC_LATENCY = 8;

  localparam int W_BITS  = $clog2(PKG_MAX_IMG_W);
  localparam int H_BITS  = $clog2(PKG_MAX_IMG_H);
  localparam int WC_BITS = $clog2(PKG_MAX_IMG_W + 1);
  localparam int HC_BITS = $clog2(PKG_MAX_IMG_H + 1);
  localparam int S_BITS  = $clog2(PKG_MAX_STRIDE + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } state_e;

  typedef struct packed {
    logic              valid;
    logic              last;
    logic [W_BITS-1:0] col;
    logic [H_BITS-1:0] row;
  } tag_t;

endpackage

// File: rtl/conv_stream_ctrl_pipe.sv
// conv_tag_pipe: enable-gated shift register of output tags.
// Ports: clk, rst_n, en_i (advance), tag_i (stage 0 in), tag_o (last stage).
module conv_tag_pipe
  import conv_ctrl_pkg::*;
#(
  parameter int DEPTH = PKG_MAC_LATENCY
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  tag_t tag_i,
  output tag_t tag_o
);

  tag_t stg_q [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stg_q[i] <= '0;
    end else if (en_i) begin
      stg_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) stg_q[i] <= stg_q[i-1];
    end
  end

  assign tag_o = stg_q[DEPTH-1];

endmodule

// File: rtl/conv_stream_ctrl.sv
// Convolution stream controller: raster counters, window qualify, tag pipe.
// Ports: start/cfg_* config, s_* input stream, m_* tagged output stream,
// shift_en/pipe_en datapath enables, busy/done/cfg_err status,
// perf_stall_cnt stall counter (only live with CONV_PERF_CNT_EN defined).
module conv_stream_ctrl
  import conv_ctrl_pkg::*;
#(
  parameter int MAX_IMG_W   = PKG_MAX_IMG_W,
  parameter int MAX_IMG_H   = PKG_MAX_IMG_H,
  parameter int NKX         = PKG_NKX,
  parameter int NKY         = PKG_NKY,
  parameter int MAX_STRIDE  = PKG_MAX_STRIDE,
  parameter int MAC_LATENCY = PKG_MAC_LATENCY
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WC_BITS-1:0] cfg_img_w,
  input  logic [HC_BITS-1:0] cfg_img_h,
  input  logic [S_BITS-1:0]  cfg_stride,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic               m_ready,
  output logic               m_valid,
  output logic [W_BITS-1:0]  m_col,
  output logic [H_BITS-1:0]  m_row,
  output logic               m_last,
  output logic               shift_en,
  output logic               pipe_en,
  output logic               busy,
  output logic               done,
  output logic               cfg_err,
  output logic [31:0]        perf_stall_cnt
);

  localparam int DC_BITS = $clog2(MAC_LATENCY + 1);
  localparam logic [WC_BITS-1:0] W_MIN = WC_BITS'(NKX);
  localparam logic [WC_BITS-1:0] W_MAX = WC_BITS'(MAX_IMG_W);
  localparam logic [HC_BITS-1:0] H_MIN = HC_BITS'(NKY);
  localparam logic [HC_BITS-1:0] H_MAX = HC_BITS'(MAX_IMG_H);
  localparam logic [S_BITS-1:0]  S_MAX = S_BITS'(MAX_STRIDE);
  localparam logic [W_BITS-1:0]  C_K   = W_BITS'(NKX - 1);
  localparam logic [H_BITS-1:0]  R_K   = H_BITS'(NKY - 1);

  state_e              state_q;
  logic [WC_BITS-1:0]  w_q;
  logic [HC_BITS-1:0]  h_q;
  logic [S_BITS-1:0]   s_q;
  logic [W_BITS-1:0]   col_q, ocol_q;
  logic [H_BITS-1:0]   row_q, orow_q;
  logic [S_BITS-1:0]   cph_q, rph_q;
  logic [DC_BITS-1:0]  dcnt_q;
  logic                cfg_err_q;

  logic                cfg_ok, accept, qual, lastq;
  logic                col_end, row_end;
  logic [W_BITS-1:0]   col_d;
  logic [H_BITS-1:0]   row_d;
  logic [S_BITS-1:0]   cph_d, rph_d;
  tag_t                tag_in, tag_out;

  always_comb begin
    cfg_ok = (cfg_img_w >= W_MIN) && (cfg_img_w <= W_MAX) &&
             (cfg_img_h >= H_MIN) && (cfg_img_h <= H_MAX) &&
             (cfg_stride != '0) && (cfg_stride <= S_MAX);
    pipe_en  = m_ready | ~m_valid;
    s_ready  = (state_q == STREAM) & pipe_en;
    accept   = s_valid & s_ready;
    shift_en = accept;
    busy     = (state_q == STREAM) | (state_q == DRAIN);
    done     = (state_q == DONE);
    cfg_err  = cfg_err_q;

    col_end = col_q == W_BITS'(w_q - 1'b1);
    row_end = row_q == H_BITS'(h_q - 1'b1);
    qual = (col_q >= C_K) && (row_q >= R_K) &&
           (cph_q == '0) && (rph_q == '0);
    // Last window: no further stride step fits in either direction.
    lastq = qual &&
      ((WC_BITS+1)'(col_q) + (WC_BITS+1)'(s_q) >= (WC_BITS+1)'(w_q)) &&
      ((HC_BITS+1)'(row_q) + (HC_BITS+1)'(s_q) >= (HC_BITS+1)'(h_q));

    col_d = col_q + 1'b1;
    row_d = row_q + 1'b1;
    // Phase restarts where the first full window lands.
    cph_d = (col_d == C_K || cph_q == s_q - 1'b1) ? '0 : cph_q + 1'b1;
    rph_d = (row_d == R_K || rph_q == s_q - 1'b1) ? '0 : rph_q + 1'b1;

    tag_in = '0;
    if (accept && qual) begin
      tag_in.valid = 1'b1;
      tag_in.last  = lastq;
      tag_in.col   = ocol_q;
      tag_in.row   = orow_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      w_q       <= '0;
      h_q       <= '0;
      s_q       <= '0;
      col_q     <= '0;
      row_q     <= '0;
      cph_q     <= '0;
      rph_q     <= '0;
      ocol_q    <= '0;
      orow_q    <= '0;
      dcnt_q    <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (start) begin
          if (cfg_ok) begin
            state_q   <= STREAM;
            cfg_err_q <= 1'b0;
            w_q       <= cfg_img_w;
            h_q       <= cfg_img_h;
            s_q       <= cfg_stride;
            col_q     <= '0;
            row_q     <= '0;
            cph_q     <= '0;
            rph_q     <= '0;
            ocol_q    <= '0;
            orow_q    <= '0;
          end else begin
            cfg_err_q <= 1'b1;
          end
        end
        STREAM: if (accept) begin
          if (col_end) begin
            col_q  <= '0;
            cph_q  <= '0;
            ocol_q <= '0;
            row_q  <= row_d;
            rph_q  <= rph_d;
            if (row_q >= R_K && rph_q == '0) orow_q <= orow_q + 1'b1;
            if (row_end) begin
              state_q <= DRAIN;
              dcnt_q  <= '0;
            end
          end else begin
            col_q <= col_d;
            cph_q <= cph_d;
            if (qual) ocol_q <= ocol_q + 1'b1;
          end
        end
        DRAIN: if (pipe_en) begin
          dcnt_q <= dcnt_q + 1'b1;
          if (dcnt_q == DC_BITS'(MAC_LATENCY - 1)) state_q <= DONE;
        end
        DONE: state_q <= IDLE;
      endcase
    end
  end

  conv_tag_pipe #(.DEPTH(MAC_LATENCY)) u_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (pipe_en),
    .tag_i (tag_in),
    .tag_o (tag_out)
  );

  assign m_valid = tag_out.valid;
  assign m_last  = tag_out.last;
  assign m_col   = tag_out.col;
  assign m_row   = tag_out.row;

`ifdef CONV_PERF_CNT_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_q <= '0;
    end else if (state_q == IDLE && start && cfg_ok) begin
      perf_q <= '0;
    end else if (busy && m_valid && !m_ready && perf_q != '1) begin
      perf_q <= perf_q + 1'b1;
    end
  end

  assign perf_stall_cnt = perf_q;
`else
  assign perf_stall_cnt = '0;
`endif

endmodule
